// File: rtl/seat_pkg.sv
// Shared types for the reading-room seat table: seat states, response codes, FSM states, table entry.
// No logic here; latency and backpressure live in the modules that import this package.
// Entry widths are the default geometry; seat_table_ctrl sizes its ID/time ports from them.
package seat_pkg;

    localparam int ENTRY_SID_W  = 32;
    localparam int ENTRY_TIME_W = 11;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        AWAY     = 2'd1,
        OCCUPIED = 2'd2,
        RESERVED = 2'd3
    } seat_state_e;

    typedef enum logic [2:0] {
        OK           = 3'd0,
        CHECKOUT     = 3'd1,
        DENIED_OWNER = 3'd2,
        DENIED_OTHER = 3'd3,
        NO_CHANGE    = 3'd4,
        BAD_REQ      = 3'd5,
        BAD_TRANS    = 3'd6
    } resp_code_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2,
        RESP   = 2'd3
    } fsm_state_e;

    typedef struct packed {
        logic [ENTRY_SID_W-1:0]  sid;
        logic [ENTRY_TIME_W-1:0] stamp;
        seat_state_e             state;
    } entry_t;

    localparam entry_t ENTRY_CLEAR = '{sid: '0, stamp: '0, state: FREE};

endpackage

// File: rtl/seat_sweeper.sv
// Round-robin expiry sweep: checks one seat per enabled cycle for AWAY entries older than the limit.
// Latency: hit is combinational on the visited entry; expire_* report is registered one cycle later.
// Backpressure: none; the pointer simply holds while enable is low.
module seat_sweeper
    import seat_pkg::*;
#(
    parameter int NUM_SEATS = 32,
    parameter int SEAT_W    = $clog2(NUM_SEATS),
    parameter int SID_W     = ENTRY_SID_W,
    parameter int TIME_W    = ENTRY_TIME_W
) (
    input  logic              clk_mem,
    input  logic              rst_mem_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [TIME_W-1:0] now_time,
    input  logic [TIME_W-1:0] away_limit,
    input  entry_t            cur_entry,
    output logic [SEAT_W-1:0] ptr,
    output logic              hit,
    output logic              expire_valid,
    output logic [SEAT_W-1:0] expire_seat,
    output logic [SID_W-1:0]  expire_sid
);

    localparam logic [SEAT_W-1:0] LAST_SEAT = SEAT_W'(NUM_SEATS - 1);

    // Unsigned modular subtraction gives the correct age across time-stamp wrap.
    logic [TIME_W-1:0] age;
    assign age = now_time - cur_entry.stamp;
    assign hit = enable && (cur_entry.state == AWAY) && (age > away_limit);

    always_ff @(posedge clk_mem or negedge rst_mem_n) begin
        if (!rst_mem_n) begin
            ptr          <= '0;
            expire_valid <= 1'b0;
            expire_seat  <= '0;
            expire_sid   <= '0;
        end else if (clear) begin
            ptr          <= '0;
            expire_valid <= 1'b0;
            expire_seat  <= '0;
            expire_sid   <= '0;
        end else begin
            expire_valid <= hit;
            if (hit) begin
                expire_seat <= ptr;
                expire_sid  <= cur_entry.sid;
            end
            if (enable) begin
                ptr <= (ptr == LAST_SEAT) ? '0 : ptr + SEAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seat_table_ctrl.sv
// Seat-state table with serialised ownership-checked updates and an idle-time AWAY expiry sweep.
// Latency: response NUM_SEATS+2 cycles after accept (2 for a malformed request).
// Backpressure: req_ready only in IDLE; resp_valid holds until resp_ready.
module seat_table_ctrl
    import seat_pkg::*;
#(
    parameter int NUM_SEATS = 32,
    parameter int SEAT_W    = $clog2(NUM_SEATS),
    parameter int SID_W     = ENTRY_SID_W,
    parameter int TIME_W    = ENTRY_TIME_W
) (
    input  logic              clk_mem,
    input  logic              rst_mem_n,
    input  logic              clear_mem,
    input  logic [TIME_W-1:0] now_time,
    input  logic [TIME_W-1:0] away_limit,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SID_W-1:0]  req_sid,
    input  logic [SEAT_W-1:0] req_seat,
    input  logic [1:0]        req_state,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [2:0]        resp_code,
    output logic              expire_valid,
    output logic [SEAT_W-1:0] expire_seat,
    output logic [SID_W-1:0]  expire_sid,
    output logic [SEAT_W:0]   occupancy
);

    localparam int                IDX_W     = $clog2(NUM_SEATS);
    localparam logic [SEAT_W-1:0] LAST_SEAT = SEAT_W'(NUM_SEATS - 1);
    localparam logic [SEAT_W:0]   OCC_MAX   = (SEAT_W + 1)'(NUM_SEATS);

    entry_t tbl [NUM_SEATS];

    fsm_state_e        state;
    logic [SEAT_W-1:0] scan_idx;
    logic [SID_W-1:0]  sid_q;
    logic [SEAT_W-1:0] seat_q;
    seat_state_e       want_q;
    logic              bad_q;
    logic              other_hit;
    resp_code_e        code_q;
    resp_code_e        code;
    logic              resp_valid_q;
    logic [SEAT_W:0]   occ;

    logic              req_bad;
    logic              accept;
    logic [SID_W-1:0]  tgt_sid;
    seat_state_e       tgt_state;
    logic [SID_W-1:0]  scan_sid;
    logic              commit_wr;
    entry_t            commit_dat;

    logic [SEAT_W-1:0] sweep_ptr;
    logic              sweep_hit;
    entry_t            sweep_entry;

    assign req_ready  = (state == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_code  = code_q;
    assign occupancy  = occ;
    assign accept     = req_valid && req_ready;
    assign req_bad    = ({1'b0, req_seat} >= OCC_MAX) || (req_sid == '0);

    assign tgt_sid     = tbl[IDX_W'(seat_q)].sid;
    assign tgt_state   = tbl[IDX_W'(seat_q)].state;
    assign scan_sid    = tbl[IDX_W'(scan_idx)].sid;
    assign sweep_entry = tbl[IDX_W'(sweep_ptr)];

    always_comb begin
        code = OK;
        if (bad_q)                                      code = BAD_REQ;
        else if (tgt_sid != '0 && tgt_sid != sid_q)     code = DENIED_OWNER;
        else if (other_hit)                             code = DENIED_OTHER;
        else if (want_q == tgt_state)                   code = NO_CHANGE;
        else if (want_q == AWAY && tgt_state == FREE)   code = BAD_TRANS;
        else if (want_q == FREE)                        code = CHECKOUT;
    end

    assign commit_wr  = (state == COMMIT) && (code == OK || code == CHECKOUT);
    assign commit_dat = (code == CHECKOUT) ? ENTRY_CLEAR
                                           : '{sid: sid_q, stamp: now_time, state: want_q};

    // The sweep is only enabled in IDLE, so its clear and the COMMIT write are mutually exclusive.
    for (genvar g = 0; g < NUM_SEATS; g++) begin : g_entry
        entry_t ent_q;
        always_ff @(posedge clk_mem or negedge rst_mem_n) begin
            if (!rst_mem_n) begin
                ent_q <= ENTRY_CLEAR;
            end else if (clear_mem) begin
                ent_q <= ENTRY_CLEAR;
            end else if (sweep_hit && IDX_W'(sweep_ptr) == IDX_W'(g)) begin
                ent_q <= ENTRY_CLEAR;
            end else if (commit_wr && IDX_W'(seat_q) == IDX_W'(g)) begin
                ent_q <= commit_dat;
            end
        end
        assign tbl[g] = ent_q;
    end

    always_ff @(posedge clk_mem or negedge rst_mem_n) begin
        if (!rst_mem_n) begin
            state        <= IDLE;
            scan_idx     <= '0;
            sid_q        <= '0;
            seat_q       <= '0;
            want_q       <= FREE;
            bad_q        <= 1'b0;
            other_hit    <= 1'b0;
            code_q       <= OK;
            resp_valid_q <= 1'b0;
            occ          <= '0;
        end else if (clear_mem) begin
            state        <= IDLE;
            scan_idx     <= '0;
            sid_q        <= '0;
            seat_q       <= '0;
            want_q       <= FREE;
            bad_q        <= 1'b0;
            other_hit    <= 1'b0;
            code_q       <= OK;
            resp_valid_q <= 1'b0;
            occ          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sweep_hit && occ != '0) begin
                        occ <= occ - (SEAT_W + 1)'(1);
                    end
                    if (accept) begin
                        sid_q     <= req_sid;
                        seat_q    <= req_seat;
                        want_q    <= seat_state_e'(req_state);
                        bad_q     <= req_bad;
                        other_hit <= 1'b0;
                        scan_idx  <= '0;
                        state     <= req_bad ? COMMIT : SCAN;
                    end
                end
                SCAN: begin
                    if (scan_sid == sid_q && scan_idx != seat_q) begin
                        other_hit <= 1'b1;
                    end
                    if (scan_idx == LAST_SEAT) begin
                        state <= COMMIT;
                    end else begin
                        scan_idx <= scan_idx + SEAT_W'(1);
                    end
                end
                COMMIT: begin
                    code_q <= code;
                    if (code == CHECKOUT && occ != '0) begin
                        occ <= occ - (SEAT_W + 1)'(1);
                    end else if (code == OK && tgt_state == FREE && occ != OCC_MAX) begin
                        occ <= occ + (SEAT_W + 1)'(1);
                    end
                    state <= RESP;
                end
                RESP: begin
                    // One registered cycle in RESP before the response is presented.
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    seat_sweeper #(
        .NUM_SEATS (NUM_SEATS),
        .SEAT_W    (SEAT_W),
        .SID_W     (SID_W),
        .TIME_W    (TIME_W)
    ) u_sweeper (
        .clk_mem      (clk_mem),
        .rst_mem_n    (rst_mem_n),
        .clear        (clear_mem),
        .enable       (state == IDLE),
        .now_time     (now_time),
        .away_limit   (away_limit),
        .cur_entry    (sweep_entry),
        .ptr          (sweep_ptr),
        .hit          (sweep_hit),
        .expire_valid (expire_valid),
        .expire_seat  (expire_seat),
        .expire_sid   (expire_sid)
    );

endmodule

// File: tb/tb_seat_table_ctrl.sv
// Directed bench for seat_table_ctrl: 32 seats with a widened 6-bit seat index so out-of-range seats can be requested.
module tb_seat_table_ctrl;

    logic        clk_mem = 1'b0;
    logic        rst_mem_n;
    logic        clear_mem;
    logic [10:0] now_time;
    logic [10:0] away_limit;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_sid;
    logic [5:0]  req_seat;
    logic [1:0]  req_state;
    logic        resp_valid;
    logic        resp_ready;
    logic [2:0]  resp_code;
    logic        expire_valid;
    logic [5:0]  expire_seat;
    logic [31:0] expire_sid;
    logic [6:0]  occupancy;

    int total = 0;
    int bad   = 0;

    seat_table_ctrl #(
        .NUM_SEATS (32),
        .SEAT_W    (6),
        .SID_W     (32),
        .TIME_W    (11)
    ) dut (
        .clk_mem      (clk_mem),
        .rst_mem_n    (rst_mem_n),
        .clear_mem    (clear_mem),
        .now_time     (now_time),
        .away_limit   (away_limit),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sid      (req_sid),
        .req_seat     (req_seat),
        .req_state    (req_state),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_code    (resp_code),
        .expire_valid (expire_valid),
        .expire_seat  (expire_seat),
        .expire_sid   (expire_sid),
        .occupancy    (occupancy)
    );

    always #5 clk_mem = ~clk_mem;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Presents a request, drops valid after the accept edge and counts cycles until resp_valid.
    task automatic send(input logic [31:0] sid, input logic [5:0] seat, input logic [1:0] st,
                        output int lat);
        req_sid   = sid;
        req_seat  = seat;
        req_state = st;
        req_valid = 1'b1;
        @(posedge clk_mem); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk_mem); #1;
            lat++;
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk_mem); #1;
        resp_ready = 1'b0;
    endtask

    task automatic do_req(input logic [31:0] sid, input logic [5:0] seat, input logic [1:0] st,
                          output logic [2:0] code, output int lat);
        send(sid, seat, st, lat);
        code = resp_code;
        consume();
    endtask

    task automatic watch_expire(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk_mem); #1;
            if (expire_valid) seen = 1'b1;
        end
    endtask

    task automatic wait_expire(input int max, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(posedge clk_mem); #1;
            if (expire_valid) seen = 1'b1;
        end
    endtask

    task automatic watch_resp(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            @(posedge clk_mem); #1;
            if (resp_valid) seen = 1'b1;
        end
    endtask

    initial begin
        logic [2:0] code;
        int         lat;
        logic       seen;

        rst_mem_n  = 1'b0;
        clear_mem  = 1'b0;
        now_time   = 11'd0;
        away_limit = 11'd50;
        req_valid  = 1'b0;
        req_sid    = '0;
        req_seat   = '0;
        req_state  = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk_mem);
        #3 rst_mem_n = 1'b1;
        @(posedge clk_mem); #1;

        check("rst_req_ready",    req_ready,    1);
        check("rst_resp_valid",   resp_valid,   0);
        check("rst_expire_valid", expire_valid, 0);
        check("rst_resp_code",    resp_code,    0);
        check("rst_expire_seat",  expire_seat,  0);
        check("rst_expire_sid",   expire_sid,   0);
        check("rst_occupancy",    occupancy,    0);

        // First occupy: full scan latency, response holds without resp_ready.
        send(32'd1001, 6'd4, 2'd2, lat);
        check("occupy_latency", lat, 34);
        check("occupy_code", resp_code, 0);
        repeat (2) @(posedge clk_mem);
        #1;
        check("resp_held", resp_valid, 1);
        consume();
        check("resp_dropped", resp_valid, 0);
        check("occupy_occ", occupancy, 1);

        do_req(32'd1002, 6'd4, 2'd2, code, lat);
        check("denied_owner", code, 2);
        do_req(32'd1001, 6'd7, 2'd2, code, lat);
        check("denied_other", code, 3);
        do_req(32'd1001, 6'd4, 2'd2, code, lat);
        check("no_change", code, 4);
        do_req(32'd1003, 6'd9, 2'd1, code, lat);
        check("bad_trans", code, 6);
        check("occ_after_denials", occupancy, 1);
        do_req(32'd1001, 6'd40, 2'd2, code, lat);
        check("bad_seat_code", code, 5);
        check("bad_seat_latency", lat, 2);
        do_req(32'd0, 6'd3, 2'd2, code, lat);
        check("bad_sid_code", code, 5);

        // AWAY stamped at 100, limit 50: age 50 holds, age 51 expires.
        now_time = 11'd100;
        do_req(32'd1001, 6'd4, 2'd1, code, lat);
        check("away_code", code, 0);
        now_time = 11'd150;
        watch_expire(40, seen);
        check("no_expire_at_limit", seen, 0);
        check("occ_before_expire", occupancy, 1);
        now_time = 11'd151;
        wait_expire(40, seen);
        check("expire_seen", seen, 1);
        check("expire_seat", expire_seat, 4);
        check("expire_sid", expire_sid, 1001);
        check("occ_after_expire", occupancy, 0);
        @(posedge clk_mem); #1;
        check("expire_pulse_len", expire_valid, 0);

        // Time-stamp wrap: stamp 2040, now 40 is age 48 against limit 48.
        away_limit = 11'd48;
        now_time   = 11'd2040;
        do_req(32'd1001, 6'd4, 2'd2, code, lat);
        check("wrap_occupy", code, 0);
        do_req(32'd1001, 6'd4, 2'd1, code, lat);
        check("wrap_away", code, 0);
        check("wrap_occ", occupancy, 1);
        now_time = 11'd40;
        watch_expire(40, seen);
        check("wrap_no_expire", seen, 0);
        now_time = 11'd41;
        wait_expire(40, seen);
        check("wrap_expire_seen", seen, 1);
        check("wrap_expire_seat", expire_seat, 4);
        check("wrap_occ_after", occupancy, 0);

        // Abort mid-scan with clear_mem.
        do_req(32'd1005, 6'd10, 2'd2, code, lat);
        check("pre_clear_code", code, 0);
        check("pre_clear_occ", occupancy, 1);
        req_sid = 32'd1006; req_seat = 6'd11; req_state = 2'd2; req_valid = 1'b1;
        @(posedge clk_mem); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk_mem);
        #1 clear_mem = 1'b1;
        @(posedge clk_mem); #1;
        clear_mem = 1'b0;
        check("clear_req_ready", req_ready, 1);
        check("clear_occ", occupancy, 0);
        watch_resp(40, seen);
        check("clear_no_resp", seen, 0);
        do_req(32'd1007, 6'd10, 2'd2, code, lat);
        check("clear_seat_freed", code, 0);
        do_req(32'd1005, 6'd12, 2'd2, code, lat);
        check("clear_owner_freed", code, 0);
        check("post_clear_occ", occupancy, 2);

        // Same abort through the asynchronous reset, asserted between edges.
        req_sid = 32'd1008; req_seat = 6'd13; req_state = 2'd2; req_valid = 1'b1;
        @(posedge clk_mem); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk_mem);
        #3 rst_mem_n = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1);
        check("arst_occ", occupancy, 0);
        check("arst_resp_valid", resp_valid, 0);
        #2 rst_mem_n = 1'b1;
        @(posedge clk_mem); #1;
        watch_resp(40, seen);
        check("arst_no_resp", seen, 0);
        do_req(32'd1009, 6'd10, 2'd2, code, lat);
        check("arst_seat_freed", code, 0);
        do_req(32'd1005, 6'd14, 2'd3, code, lat);
        check("arst_owner_freed", code, 0);
        check("post_arst_occ", occupancy, 2);

        // Checkout returns the seat and decrements occupancy.
        do_req(32'd1005, 6'd14, 2'd0, code, lat);
        check("checkout_code", code, 1);
        check("checkout_occ", occupancy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seat_table_ctrl.md
Name: seat_table_ctrl

Overview:
- Clocked, parametrised seat-state table for the reading-room seating system.
- Serialises student requests through a valid/ready handshake.
- Enforces ownership and one-seat-per-student rules with a sequential scan.
- Sweeps for seats left AWAY too long, returns them to FREE and reports each return on an event port. Sits between the kiosk/command decoder and the display/log logic.

Parameters:
- NUM_SEATS, 32, number of seats; index width SEAT_W = $clog2(NUM_SEATS).
- SID_W, 32, student ID width; ID 0 means "no owner".
- TIME_W, 11, width of the time stamp and of the away limit.

Ports:
- clk_mem  in  1  clock.
- rst_mem_n  in  1  asynchronous active-low reset.
- clear_mem  in  1  synchronous table clear, highest priority.
- now_time  in  TIME_W  free-running time stamp; wraps modulo 2^TIME_W.
- away_limit  in  TIME_W  maximum AWAY duration.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_sid  in  SID_W  requesting student.
- req_seat  in  SEAT_W  target seat.
- req_state  in  2  requested state: 0 FREE, 1 AWAY, 2 OCCUPIED, 3 RESERVED.
- resp_valid  out  1  response present; held until resp_ready.
- resp_ready  in  1  response consumed.
- resp_code  out  3  result code.
- expire_valid  out  1  one-cycle pulse per auto-return.
- expire_seat  out  SEAT_W  seat returned by the sweep.
- expire_sid  out  SID_W  former owner of the returned seat.
- occupancy  out  SEAT_W+1  count of non-FREE seats.

Behaviour:
- Reset (rst_mem_n low, asynchronous):
  - All table entries cleared: sid 0, time 0, state FREE.
  - FSM in IDLE; sweep pointer 0.
  - req_ready=1; resp_valid=0; expire_valid=0; resp_code=0; expire_seat=0; expire_sid=0; occupancy=0.
- clear_mem=1: same effect as reset, but on the clock edge. Any in-flight request and pending response are dropped, and no response is issued for them.
- FSM states and transitions:
  - IDLE -> SCAN on req_valid && req_ready.
  - SCAN visits one seat per cycle (index 0..NUM_SEATS-1). It flags any seat i != req_seat whose sid == req_sid.
  - SCAN -> COMMIT after index NUM_SEATS-1.
  - COMMIT -> RESP.
  - RESP -> IDLE when resp_ready.
- Request fields are latched on acceptance.
- Latency: resp_valid rises exactly NUM_SEATS+2 cycles after the accept edge. A bad request skips SCAN and responds 2 cycles after the accept edge.
- Decision, evaluated in COMMIT in this priority order:
  1. Bad request (req_seat >= NUM_SEATS, or req_sid == 0) -> BAD_REQ (5). Detected at accept; skips SCAN.
  2. Seat owner is neither 0 nor req_sid -> DENIED_OWNER (2).
  3. Student already holds another seat -> DENIED_OTHER (3).
  4. req_state equals the current state -> NO_CHANGE (4).
  5. req_state=AWAY while the seat is FREE -> BAD_TRANS (6).
  6. req_state=FREE -> entry cleared; code CHECKOUT (1).
  7. Otherwise -> entry written {req_sid, now_time, req_state}; code OK (0).
- The table is written only on the COMMIT edge. Occupancy is updated on the same edge.
- Sweep:
  - Active only in IDLE; one seat per cycle, pointer wraps NUM_SEATS-1 -> 0.
  - Pointer holds while not in IDLE.
  - Expiry condition: state==AWAY and (now_time - time) mod 2^TIME_W > away_limit (strictly greater). A difference equal to the limit does not expire.
  - On expiry: entry cleared, occupancy decremented, and expire_valid pulses on the next cycle with the seat and former sid.
- Simultaneous sweep expiry and request accept in IDLE: expiry is applied on that edge, so SCAN and COMMIT see the updated table.
- The sweep never runs during COMMIT, so sweep and request writes never collide.
- Occupancy saturates at NUM_SEATS and never underflows. Never assert on this; it is guaranteed by construction.

Decomposition:
- Package seat_pkg holds:
  - seat_state_e (FREE, AWAY, OCCUPIED, RESERVED).
  - resp_code_e (OK, CHECKOUT, DENIED_OWNER, DENIED_OTHER, NO_CHANGE, BAD_REQ, BAD_TRANS).
  - fsm_state_e (IDLE, SCAN, COMMIT, RESP).
  - Entry struct {sid, time, state}.
- Sub-module seat_sweeper: owns the sweep pointer and the expiry compare. It outputs an expire strobe, seat and sid. The top owns the table and the FSM.

Test Plan:
- Reset, then sid 1001 requests seat 4 state 2 -> resp OK after 34 cycles; occupancy=1.
- sid 1002 requests seat 4 state 2 -> DENIED_OWNER. sid 1001 requests seat 7 -> DENIED_OTHER.
- sid 1001 requests seat 4 state 1 at now_time 100 with away_limit 50:
  - At time 150 -> no expiry.
  - At time 151 -> expire_valid with seat 4, sid 1001; occupancy=0.
- Wrap-around: AWAY stamped at 2040, now_time 40, limit 48 -> difference 48, no expiry. At now_time 41 -> expiry.
- Request state 1 on a FREE seat -> BAD_TRANS. req_seat 40 with NUM_SEATS=32 (SEAT_W widened in the bench build) -> BAD_REQ after 2 cycles. Repeat an identical state -> NO_CHANGE.
- clear_mem mid-SCAN -> resp_valid never rises, all seats FREE, occupancy 0, req_ready=1 next cycle. Repeat the same abort using rst_mem_n.
